score_display_driver: RTL and testbench
=======================================

// Module: score_display_driver
// PURPOSE
//  Consumes the 16-bit binary score / p2score / highscore from the game controller and drives an 8-digit,
//  common-anode seven-segment display. A sequential double-dabble converter turns each value to 4-digit BCD;
//  a refresh counter time-multiplexes the digits. Right group (digits 3..0) = score; left group (digits 7..4)
//  = p2score when two_player, else highscore. Runs on the same clk/rst as the game controller.
// PARAMETERS
//  REFRESH_BITS  18    refresh counter width; digit select = refresh_cnt[REFRESH_BITS-1 -: 3]
//  DISPLAY_MAX   9999  saturation ceiling applied before conversion
// PORTS
//  clk         in   1   system clock, single domain
//  rst         in   1   asynchronous, active-high reset
//  score       in   16  player-1 score, binary
//  p2score     in   16  player-2 score, binary
//  highscore   in   16  high score, binary
//  two_player  in   1   1: left group shows p2score; 0: left group shows highscore
//  an          out  8   digit anodes, active-low, an[0] = rightmost digit
//  ssd         out  8   {dp,g,f,e,d,c,b,a}, active-low
//  score_bcd   out  16  latched BCD of right group (test observability)
//  left_bcd    out  16  latched BCD of left group (test observability)
//  busy        out  1   converter not in IDLE
// BEHAVIOUR
//  Reset (async, rst=1): an=8'hFF, ssd=8'hFF, score_bcd=0, left_bcd=0, busy=0, refresh_cnt=0,
//   FSM=IDLE, channel=0. Reset mid-conversion aborts; partial result discarded, latched BCD stays 0.
//  Converter FSM: IDLE -> LOAD -> SHIFT x16 -> DONE -> IDLE.
//   IDLE (1 cyc): always advances to LOAD next cycle (continuous round-robin).
//   LOAD: snapshot source for current channel (0: score; 1: two_player ? p2score : highscore), sampled
//    this cycle only; value > DISPLAY_MAX replaced by DISPLAY_MAX. two_player sampled here, also latched as mode.
//   SHIFT: 16 cycles; each cycle every BCD nibble >= 5 gets +3, then {bcd,bin} shifts left 1. Shift count 4-bit.
//   DONE: copy 16-bit BCD into score_bcd (ch 0) or left_bcd + left mode (ch 1) atomically; toggle channel.
//   Per-value latency 19 cycles (IDLE..DONE); both groups refreshed every 38 cycles.
//   Input changes during SHIFT ignored until next LOAD of that channel; no tearing of displayed digits.
//  busy=1 in LOAD/SHIFT/DONE, 0 in IDLE.
//  Scan: refresh_cnt free-running, wraps 2^REFRESH_BITS-1 -> 0. Digit k = select field.
//   an, ssd registered: reflect the select value of the previous cycle (1-cycle latency);
//   exactly one an bit low at all times after the first post-reset clock.
//  Decode: nibble 0-9 -> standard patterns (0 = seg 7'b1000000, i.e. ssd=8'hC0 with dp off);
//   nibble 10-15 unreachable; drive all segments off if seen.
//  Leading-zero blanking per group: digit blanked (ssd=8'hFF, anode still cycles) when it and all
//   higher digits of its group are 0; digit 0 and digit 4 never blanked.
//  dp: lit (ssd[7]=0) only on digit 4 when latched left mode = highscore (two_player=0); else off.
//  Width rules: inputs 16-bit unsigned; BCD 4 nibbles; no arithmetic wider than 20 bits internally.
// TESTING (bench uses REFRESH_BITS=6: 8 cycles per digit)
//  1 rst pulse, all inputs 0 -> an=FF, ssd=FF during rst; 40 cyc later digit0 ssd=8'hC0, digits 1-3 ssd=FF,
//    digit4 ssd=8'h40 (dp lit, highscore mode).
//  2 score=1234 held -> score_bcd=16'h1234 within 38 cyc; digits 0..3 show 4,3,2,1 (ssd 99,B0,A4,F9).
//  3 score=12000 -> score_bcd=16'h9999; score=65535 -> 16'h9999.
//  4 score=7 -> digit0 ssd=8'hF8, digits 1-3 ssd=FF while their an bit is low.
//  5 highscore=42, p2score=5, two_player=0 -> left_bcd=16'h0042, dp on digit4; set two_player=1 ->
//    within 38 cyc left_bcd=16'h0005, dp off.
//  6 assert rst while busy=1 mid-SHIFT with score=999 -> outputs return to reset values immediately;
//    after release, score_bcd=16'h0999 within 38 cyc, never an intermediate value.

Source files
------------

// File: rtl/score_display_driver_if.sv
// Signal bundle between the game controller and the score display driver.
// The master drives the binary scores and mode. The slave drives the display and observability outputs.
interface score_display_driver_if;
  logic [15:0] score;
  logic [15:0] p2score;
  logic [15:0] highscore;
  logic        two_player;
  logic [7:0]  an;
  logic [7:0]  ssd;
  logic [15:0] score_bcd;
  logic [15:0] left_bcd;
  logic        busy;

  modport master (
    output score, p2score, highscore, two_player,
    input  an, ssd, score_bcd, left_bcd, busy
  );

  modport slave (
    input  score, p2score, highscore, two_player,
    output an, ssd, score_bcd, left_bcd, busy
  );
endinterface

// File: rtl/score_display_driver.sv
// Round-robin double-dabble conversion of two 16-bit scores to BCD, with an 8-digit
// multiplexed common-anode seven-segment scan that blanks leading zeros.
module score_display_driver #(
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned DISPLAY_MAX  = 9999
) (
  input  logic                   clk,
  input  logic                   rst,
  score_display_driver_if.slave  bus_io
);

  localparam logic [15:0] DispMax = 16'(DISPLAY_MAX);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  shift_cnt_q, shift_cnt_d;
  logic [15:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic        chan_q, chan_d;
  logic        conv_mode_q, conv_mode_d;
  logic [15:0] score_bcd_q, score_bcd_d;
  logic [15:0] left_bcd_q, left_bcd_d;
  logic        left_mode_q, left_mode_d;
  logic        busy;

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [7:0]              an_q, an_d;
  logic [7:0]              ssd_q, ssd_d;

  logic [15:0] src;
  logic [15:0] bcd_adj;
  logic        unused_bcd_msb;

  // ---------------------------------------------------------------------------
  // Converter FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (shift_cnt_q == 4'd15) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------------
  assign src = chan_q ? (bus_io.two_player ? bus_io.p2score : bus_io.highscore) : bus_io.score;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // The adjusted MSB is shifted out and lost; it is always 0 for values up to 9999.
  assign unused_bcd_msb = bcd_adj[15];

  always_comb begin
    shift_cnt_d = shift_cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    chan_d      = chan_q;
    conv_mode_d = conv_mode_q;
    score_bcd_d = score_bcd_q;
    left_bcd_d  = left_bcd_q;
    left_mode_d = left_mode_q;
    unique case (state_q)
      StLoad: begin
        bin_d       = (src > DispMax) ? DispMax : src;
        bcd_d       = '0;
        shift_cnt_d = '0;
        conv_mode_d = bus_io.two_player;
      end
      StShift: begin
        bcd_d       = {bcd_adj[14:0], bin_q[15]};
        bin_d       = {bin_q[14:0], 1'b0};
        shift_cnt_d = shift_cnt_q + 4'd1;
      end
      StDone: begin
        if (chan_q) begin
          left_bcd_d  = bcd_q;
          left_mode_d = conv_mode_q;
        end else begin
          score_bcd_d = bcd_q;
        end
        chan_d = ~chan_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt_q <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      chan_q      <= 1'b0;
      conv_mode_q <= 1'b0;
      score_bcd_q <= '0;
      left_bcd_q  <= '0;
      left_mode_q <= 1'b0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      chan_q      <= chan_d;
      conv_mode_q <= conv_mode_d;
      score_bcd_q <= score_bcd_d;
      left_bcd_q  <= left_bcd_d;
      left_mode_q <= left_mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan and segment decode
  // ---------------------------------------------------------------------------
  logic [2:0]  sel;
  logic [1:0]  pos;
  logic [15:0] grp;
  logic [3:0]  nib;
  logic [6:0]  seg;
  logic        blank;
  logic        dp_n;

  assign sel = refresh_q[REFRESH_BITS-1 -: 3];
  assign pos = sel[1:0];
  assign grp = sel[2] ? left_bcd_q : score_bcd_q;
  assign nib = grp[4*pos +: 4];

  always_comb begin
    unique case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

  // A digit is blank when it and every higher digit of its group are zero.
  always_comb begin
    blank = 1'b0;
    unique case (pos)
      2'd3:    blank = (grp[15:12] == 4'd0);
      2'd2:    blank = (grp[15:8] == 8'd0);
      2'd1:    blank = (grp[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end

  assign dp_n = !((sel == 3'd4) && !left_mode_q);

  always_comb begin
    an_d  = ~(8'h01 << sel);
    ssd_d = blank ? 8'hFF : {dp_n, seg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      an_q      <= 8'hFF;
      ssd_q     <= 8'hFF;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      an_q      <= an_d;
      ssd_q     <= ssd_d;
    end
  end

  assign bus_io.an        = an_q;
  assign bus_io.ssd       = ssd_q;
  assign bus_io.score_bcd = score_bcd_q;
  assign bus_io.left_bcd  = left_bcd_q;
  assign bus_io.busy      = busy;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver with an 8-cycle digit period.
module tb_score_display_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  score_display_driver_if bus ();

  score_display_driver #(
    .REFRESH_BITS(6),
    .DISPLAY_MAX (9999)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bcd(input bit left, input logic [15:0] val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((left ? bus.left_bcd : bus.score_bcd) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_digit(input int k, output bit ok);
    logic [7:0] tgt;
    tgt = ~(8'h01 << k);
    ok  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.an === tgt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    bus.score = 16'd0; bus.p2score = 16'd0; bus.highscore = 16'd0; bus.two_player = 1'b0;
    rst = 1'b1;
    tick(2);
    checks++;
    if (bus.an !== 8'hFF || bus.ssd !== 8'hFF) begin
      errors++; $display("FAIL rst_display an=%h ssd=%h required an=FF ssd=FF", bus.an, bus.ssd);
    end
    checks++;
    if (bus.score_bcd !== 16'h0 || bus.left_bcd !== 16'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_state score_bcd=%h left_bcd=%h busy=%b required 0/0/0",
               bus.score_bcd, bus.left_bcd, bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_rst busy=%b required 0", bus.busy);
    end
    tick(40);
    wait_digit(0, ok);
    checks++;
    if (!ok || bus.ssd !== 8'hC0) begin
      errors++; $display("FAIL zero_d0 ssd=%h found=%b required C0", bus.ssd, ok);
    end
    for (int k = 1; k < 4; k++) begin
      wait_digit(k, ok);
      checks++;
      if (!ok || bus.ssd !== 8'hFF) begin
        errors++; $display("FAIL zero_blank_d%0d ssd=%h found=%b required FF", k, bus.ssd, ok);
      end
    end
    wait_digit(4, ok);
    checks++;
    if (!ok || bus.ssd !== 8'h40) begin
      errors++; $display("FAIL zero_d4_dp ssd=%h found=%b required 40", bus.ssd, ok);
    end
  endtask

  task automatic test_scan();
    logic [7:0] seen;
    bit         bad;
    seen = 8'h00;
    bad  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ($countones(~bus.an) != 1) bad = 1'b1;
      seen = seen | ~bus.an;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL scan_onehot an=%h required exactly one low bit", bus.an);
    end
    checks++;
    if (seen !== 8'hFF) begin
      errors++; $display("FAIL scan_coverage seen=%h required FF", seen);
    end
  endtask

  task automatic test_convert();
    bit         ok;
    logic [7:0] exp_ssd [4];
    exp_ssd = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    bus.score = 16'd1234;
    wait_bcd(1'b0, 16'h1234, ok);
    checks++;
    if (bus.score_bcd !== 16'h1234) begin
      errors++; $display("FAIL conv_1234 score_bcd=%h required 1234", bus.score_bcd);
    end
    for (int k = 0; k < 4; k++) begin
      wait_digit(k, ok);
      checks++;
      if (!ok || bus.ssd !== exp_ssd[k]) begin
        errors++; $display("FAIL digit_1234_d%0d ssd=%h found=%b required %h", k, bus.ssd, ok,
                           exp_ssd[k]);
      end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    bus.score = 16'd12000;
    wait_bcd(1'b0, 16'h9999, ok);
    checks++;
    if (bus.score_bcd !== 16'h9999) begin
      errors++; $display("FAIL sat_12000 score_bcd=%h required 9999", bus.score_bcd);
    end
    wait_digit(3, ok);
    checks++;
    if (!ok || bus.ssd !== 8'h90) begin
      errors++; $display("FAIL sat_d3 ssd=%h found=%b required 90", bus.ssd, ok);
    end
    bus.score = 16'd5;
    wait_bcd(1'b0, 16'h0005, ok);
    checks++;
    if (bus.score_bcd !== 16'h0005) begin
      errors++; $display("FAIL conv_5 score_bcd=%h required 0005", bus.score_bcd);
    end
    bus.score = 16'd65535;
    wait_bcd(1'b0, 16'h9999, ok);
    checks++;
    if (bus.score_bcd !== 16'h9999) begin
      errors++; $display("FAIL sat_65535 score_bcd=%h required 9999", bus.score_bcd);
    end
  endtask

  task automatic test_blanking();
    bit ok;
    bus.score = 16'd7;
    wait_bcd(1'b0, 16'h0007, ok);
    checks++;
    if (bus.score_bcd !== 16'h0007) begin
      errors++; $display("FAIL conv_7 score_bcd=%h required 0007", bus.score_bcd);
    end
    wait_digit(0, ok);
    checks++;
    if (!ok || bus.ssd !== 8'hF8) begin
      errors++; $display("FAIL seven_d0 ssd=%h found=%b required F8", bus.ssd, ok);
    end
    for (int k = 1; k < 4; k++) begin
      wait_digit(k, ok);
      checks++;
      if (!ok || bus.ssd !== 8'hFF) begin
        errors++; $display("FAIL seven_blank_d%0d ssd=%h found=%b required FF", k, bus.ssd, ok);
      end
    end
  endtask

  task automatic test_left_mode();
    bit ok;
    bus.highscore  = 16'd42;
    bus.p2score    = 16'd5;
    bus.two_player = 1'b0;
    wait_bcd(1'b1, 16'h0042, ok);
    checks++;
    if (bus.left_bcd !== 16'h0042) begin
      errors++; $display("FAIL high_42 left_bcd=%h required 0042", bus.left_bcd);
    end
    wait_digit(4, ok);
    checks++;
    if (!ok || bus.ssd !== 8'h24) begin
      errors++; $display("FAIL high_d4_dp ssd=%h found=%b required 24", bus.ssd, ok);
    end
    wait_digit(5, ok);
    checks++;
    if (!ok || bus.ssd !== 8'h99) begin
      errors++; $display("FAIL high_d5 ssd=%h found=%b required 99", bus.ssd, ok);
    end
    wait_digit(6, ok);
    checks++;
    if (!ok || bus.ssd !== 8'hFF) begin
      errors++; $display("FAIL high_blank_d6 ssd=%h found=%b required FF", bus.ssd, ok);
    end
    bus.two_player = 1'b1;
    wait_bcd(1'b1, 16'h0005, ok);
    checks++;
    if (bus.left_bcd !== 16'h0005) begin
      errors++; $display("FAIL p2_5 left_bcd=%h required 0005", bus.left_bcd);
    end
    wait_digit(4, ok);
    checks++;
    if (!ok || bus.ssd !== 8'h92) begin
      errors++; $display("FAIL p2_d4_nodp ssd=%h found=%b required 92", bus.ssd, ok);
    end
    wait_digit(5, ok);
    checks++;
    if (!ok || bus.ssd !== 8'hFF) begin
      errors++; $display("FAIL p2_blank_d5 ssd=%h found=%b required FF", bus.ssd, ok);
    end
  endtask

  task automatic test_reset_mid();
    bit          ok;
    bit          torn;
    logic [15:0] bad_val;
    bus.score = 16'd999;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tick(6);
    checks++;
    if (!ok || bus.busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy busy=%b idle_seen=%b required 1", bus.busy, ok);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.an !== 8'hFF || bus.ssd !== 8'hFF || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out an=%h ssd=%h busy=%b required FF/FF/0",
                         bus.an, bus.ssd, bus.busy);
    end
    checks++;
    if (bus.score_bcd !== 16'h0 || bus.left_bcd !== 16'h0) begin
      errors++; $display("FAIL mid_rst_bcd score_bcd=%h left_bcd=%h required 0/0",
                         bus.score_bcd, bus.left_bcd);
    end
    tick(2);
    rst     = 1'b0;
    torn    = 1'b0;
    bad_val = 16'h0;
    ok      = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.score_bcd !== 16'h0 && bus.score_bcd !== 16'h0999) begin
        torn    = 1'b1;
        bad_val = bus.score_bcd;
      end
      if (bus.score_bcd === 16'h0999) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (torn) begin
      errors++; $display("FAIL mid_no_tear score_bcd=%h required 0000 or 0999", bad_val);
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_recover score_bcd=%h required 0999", bus.score_bcd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_scan();
    test_convert();
    test_saturate();
    test_blanking();
    test_left_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
